i2s_tx_sample_unpacker: RTL
===========================

// Module: i2s_tx_sample_unpacker
// PURPOSE
//  Upstream feeder of the I2S/DSP TX channel, on the same sck_i domain. Takes 32-bit words from the
//  uDMA TX path, splits packed words into 1/2/4 right-justified samples and buffers them in a FWFT FIFO.
//  Drives the channel's fifo_data/valid/ready interface and flags underruns.
// PARAMETERS
//  DEPTH   8   sample FIFO entries; power of 2, >=2
//  DATA_W  32  sample/word width; fixed at 32
// PORTS
//  sck_i              in   1      serial bit clock; sole clock
//  rst_i              in   1      asynchronous, active-high reset
//  in_data_i          in   32     packed word from uDMA TX path
//  in_valid_i         in   1      in_data_i valid
//  in_ready_o         out  1      word accepted when in_valid_i & in_ready_o
//  fifo_data_o        out  32     sample to TX channel, right-justified
//  fifo_data_valid_o  out  1      FIFO non-empty
//  fifo_data_ready_i  in   1      channel pops; pop = valid & ready
//  fifo_err_o         out  1      1-cycle underrun pulse
//  fifo_level_o       out  clog2(DEPTH)+1  current FIFO occupancy
//  cfg_en_i           in   1      0 = synchronous flush/idle
//  cfg_pack_mode_i    in   2      0: 1x32, 1: 2x16, 2: 4x8, 3: reserved (treated as 0)
//  cfg_sign_ext_i     in   1      1 = sign-extend 8/16-bit samples, 0 = zero-extend
// BEHAVIOUR
//  Reset: in_ready_o=0, fifo_data_o=0, fifo_data_valid_o=0, fifo_err_o=0, fifo_level_o=0.
//  Reset also clears the holding register, sample index, primed flag and FIFO pointers.
//  Holding register (hold_valid, hold_word, idx):
//   - Word accepted at edge N: hold_valid=1, idx=0.
//   - One sample is pushed per cycle while hold_valid & !full.
//   - Sample k = word[k*W +: W] (W=32/16/8). Lowest lane goes first.
//  in_ready_o = cfg_en_i & (!hold_valid | (last sample pushing this cycle)).
//   - Back-to-back words therefore run with no bubble.
//  cfg_pack_mode_i is sampled at word accept and held per word; mid-word changes take effect on the next word.
//  FIFO: first-word-fall-through, registered count.
//   - Latency: word accepted edge N -> sample 0 written edge N+1 -> fifo_data_valid_o=1 after edge N+1.
//   - Push blocked when full, even if a pop happens in the same cycle.
//   - Pop when empty is a no-op.
//   - Simultaneous push+pop when not full: level unchanged.
//   - Pointers wrap mod DEPTH.
//  Underrun: primed flag set on first pop after enable.
//   - fifo_err_o=1 for one cycle when primed & fifo_data_ready_i & !fifo_data_valid_o.
//   - Not primed: no error, which covers channel prefill before data arrives.
//  cfg_en_i=0 (level): same-edge flush of holding register, FIFO and primed flag; in_ready_o=0, valid=0.
//   - Any in-flight word is dropped.
//   - Re-enable starts clean.
//  rst_i mid-operation: immediate clear to reset values, independent of sck_i.
// CONFIGURATION
//  Macro I2S_TX_UNDERRUN_CNT_EN:
//   - Defined: adds output port underrun_cnt_o [15:0]. It increments on every fifo_err_o pulse,
//     saturates at 16'hFFFF, and clears on rst_i or cfg_en_i=0.
//   - Undefined: port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Package i2s_tx_pkg:
//   - typedef enum logic[1:0] pack_mode_e {PACK_1x32, PACK_2x16, PACK_4x8, PACK_RSVD}.
//   - Function samples_per_word(pack_mode_e).
//   - Function extract_sample(word, mode, idx, sext).
//  One sub-module, i2s_tx_sample_fifo #(DEPTH), contains the FWFT FIFO with push/pop/flush/level.
//  Unpack control, the primed flag and the underrun logic sit at top level.
// TESTING
//  1. mode 0, words 0xA1B2C3D4 and 0x11223344, ready=1 -> same two samples out in order, valid first at N+1, no err.
//  2. mode 1, sext=1, word 0x8001_7FFF -> 0x00007FFF then 0xFFFF8001; in_ready_o low one cycle.
//  3. mode 2, sext=0, word 0xFF80_0102, ready=0 -> level=4; samples then pop as 0x02, 0x01, 0x80, 0xFF.
//  4. Fill with ready=0 -> level=DEPTH, in_ready_o=0. Then ready=1 for one cycle -> level DEPTH-1 and no push that cycle.
//  5. Prime with one pop, then hold ready=1 with FIFO empty for 3 cycles -> 3 err pulses; underrun_cnt_o=3 if macro set.
//  6. cfg_en_i=0 with level=5 mid-word -> next edge level=0, valid=0. Re-enable with ready=1, empty -> no err until primed.

Source files
------------

// File: rtl/i2s_tx_pkg.sv
// rtl/i2s_tx_pkg.sv - pack-mode type and sample lane helpers for the I2S TX unpacker
package i2s_tx_pkg;

  typedef enum logic [1:0] {
    PACK_1x32 = 2'd0,
    PACK_2x16 = 2'd1,
    PACK_4x8  = 2'd2,
    PACK_RSVD = 2'd3
  } pack_mode_e;

  // Reserved mode behaves as one full-width sample per word.
  function automatic logic [2:0] samples_per_word(input pack_mode_e mode);
    case (mode)
      PACK_2x16: return 3'd2;
      PACK_4x8:  return 3'd4;
      default:   return 3'd1;
    endcase
  endfunction

  function automatic logic [31:0] extract_sample(input logic [31:0] word,
                                                 input pack_mode_e  mode,
                                                 input logic [1:0]  idx,
                                                 input logic        sext);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [31:0] s;
    half_v = idx[0] ? word[31:16] : word[15:0];
    case (idx)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    case (mode)
      PACK_2x16: s = {{16{sext & half_v[15]}}, half_v};
      PACK_4x8:  s = {{24{sext & byte_v[7]}}, byte_v};
      default:   s = word;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/i2s_tx_sample_fifo.sv
// rtl/i2s_tx_sample_fifo.sv - first-word-fall-through sample FIFO with registered level and flush
module i2s_tx_sample_fifo
  #(parameter int DEPTH  = 8,
    parameter int DATA_W = 32)
  (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
  );

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              empty, push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign valid_o = ~empty;
  assign level_o = count_q;
  // Output is forced to zero while empty so the unwritten storage never shows.
  assign data_o  = empty ? '0 : mem_q[rd_ptr_q];

  // A pop never frees space for a push in the same cycle.
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/i2s_tx_sample_unpacker.sv
// rtl/i2s_tx_sample_unpacker.sv - splits uDMA TX words into samples for the I2S channel
// Optional underrun counter port underrun_cnt_o is enabled by I2S_TX_UNDERRUN_CNT_EN.
module i2s_tx_sample_unpacker
  import i2s_tx_pkg::*;
  #(parameter int DEPTH  = 8,
    parameter int DATA_W = 32)
  (
  input  logic                     sck_i,
  input  logic                     rst_i,
  input  logic [DATA_W-1:0]        in_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [DATA_W-1:0]        fifo_data_o,
  output logic                     fifo_data_valid_o,
  input  logic                     fifo_data_ready_i,
  output logic                     fifo_err_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o,
  input  logic                     cfg_en_i,
  input  logic [1:0]               cfg_pack_mode_i,
  input  logic                     cfg_sign_ext_i
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]              underrun_cnt_o
`endif
  );

  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] hold_word_q, hold_word_d;
  logic [1:0]        idx_q, idx_d;
  pack_mode_e        mode_q, mode_d;
  logic              primed_q, primed_d;

  logic              fifo_full, push, last_sample, accept, pop;
  logic [DATA_W-1:0] sample;

  assign last_sample = ({1'b0, idx_q} == (samples_per_word(mode_q) - 3'd1));
  assign push        = cfg_en_i & hold_valid_q & ~fifo_full;
  // Ready while the last lane drains lets back-to-back words stream without a bubble.
  assign in_ready_o  = cfg_en_i & ~rst_i & (~hold_valid_q | (push & last_sample));
  assign accept      = in_valid_i & in_ready_o;
  assign pop         = fifo_data_valid_o & fifo_data_ready_i;
  assign fifo_err_o  = cfg_en_i & primed_q & fifo_data_ready_i & ~fifo_data_valid_o;
  assign sample      = extract_sample(hold_word_q, mode_q, idx_q, cfg_sign_ext_i);

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_word_d  = hold_word_q;
    idx_d        = idx_q;
    mode_d       = mode_q;
    primed_d     = primed_q | pop;
    if (!cfg_en_i) begin
      hold_valid_d = 1'b0;
      idx_d        = '0;
      primed_d     = 1'b0;
    end else if (accept) begin
      hold_valid_d = 1'b1;
      hold_word_d  = in_data_i;
      idx_d        = '0;
      mode_d       = pack_mode_e'(cfg_pack_mode_i);
    end else if (push) begin
      if (last_sample) hold_valid_d = 1'b0;
      else             idx_d        = idx_q + 2'd1;
    end
  end

  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid_q <= 1'b0;
      hold_word_q  <= '0;
      idx_q        <= '0;
      mode_q       <= PACK_1x32;
      primed_q     <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_word_q  <= hold_word_d;
      idx_q        <= idx_d;
      mode_q       <= mode_d;
      primed_q     <= primed_d;
    end
  end

  i2s_tx_sample_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk_i   (sck_i),
    .rst_i   (rst_i),
    .flush_i (~cfg_en_i),
    .push_i  (push),
    .data_i  (sample),
    .pop_i   (fifo_data_ready_i),
    .data_o  (fifo_data_o),
    .valid_o (fifo_data_valid_o),
    .full_o  (fifo_full),
    .level_o (fifo_level_o)
  );

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q;

  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) begin
      underrun_cnt_q <= '0;
    end else if (!cfg_en_i) begin
      underrun_cnt_q <= '0;
    end else if (fifo_err_o && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign underrun_cnt_o = underrun_cnt_q;
`endif

endmodule
